sevenseg_scan: RTL and testbench

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display, the output-side counterpart of the pushbutton input conditioning. It takes a 32-bit hex value plus per-digit enable and decimal-point masks and scans one digit at a time. Each digit slot starts with a blanking guard to prevent ghosting. Inputs are snapshotted once per frame so that a value changing mid-scan never tears.

---
 rtl/sevenseg_pkg.sv | 23 ++
 rtl/hex_to_seg.sv | 17 +
 rtl/sevenseg_scan.sv | 127 ++++++++++++
 tb/tb_sevenseg_scan.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: hex-to-segment table, blank pattern, scan phase type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sevenseg_pkg;

    // Segment pattern with every segment off (active low, {g,f,e,d,c,b,a}).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs indexed by nibble value; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Position within a digit slot: guard interval with anodes off, then lit.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   nibble  in   4  hex value to display
//   seg     out  7  segments {g,f,e,d,c,b,a}, active low
module hex_to_seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 8-digit common-anode display driver with per-slot blanking guard.
// Latency: outputs registered, one cycle behind the internal slot counter and digit index.
// Backpressure: none; free-running scan, inputs sampled once per frame and ignored otherwise.
//
// Ports:
//   clk         in   1               system clock
//   rst         in   1               asynchronous active-high reset
//   data        in   4*NUM_DIGITS    hex nibbles, nibble i shown on digit i (digit 0 rightmost)
//   digit_en    in   NUM_DIGITS      1 = digit i lit
//   dp          in   NUM_DIGITS      1 = decimal point of digit i lit
//   an          out  NUM_DIGITS      anodes, active low
//   seg         out  7               segments {g,f,e,d,c,b,a}, active low
//   dp_n        out  1               decimal point, active low
//   frame_tick  out  1               one-cycle pulse after each input snapshot
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic                      frame_tick
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    // The guard must exist and must leave at least one lit cycle per slot.
    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
            $error("sevenseg_scan: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIGIT_CYCLES");
        end
    endgenerate

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    frame_start;
    phase_t                  phase;
    logic [3:0]              nibble;
    logic [6:0]              nib_seg;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_n_d;

    // First cycle of digit 0: always inside BLANK, so reloading the shadow
    // here can never change what a lit digit shows.
    assign frame_start = (cnt == '0) && (idx == '0);

    // Slot counter and digit index. Disabled digits still take their full slot,
    // which keeps the frame period fixed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Per-frame input snapshot; cleared shadow means a dark display after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_en   <= '0;
            shadow_dp   <= '0;
        end else if (frame_start) begin
            shadow_data <= data;
            shadow_en   <= digit_en;
            shadow_dp   <= dp;
        end
    end

    assign nibble = shadow_data[{idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (nib_seg)
    );

    // Output decode for the current slot position. A disabled digit still
    // drives its segments; only its anode is held off.
    always_comb begin
        phase  = (cnt < BLANK_END) ? BLANK : DRIVE;
        an_d   = '1;
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        if (phase == DRIVE) begin
            an_d[idx] = ~shadow_en[idx];
            seg_d     = nib_seg;
            dp_n_d    = ~shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp_n       <= dp_n_d;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with a small frame (8 digits, 8-cycle slots, 2-cycle guard).
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_sevenseg_scan;

    localparam int ND    = 8;
    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * DC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  digit_en;
    logic [7:0]  dp;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_tick;

    sevenseg_scan #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .digit_en   (digit_en),
        .dp         (dp),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Decode vectors: nibble and its required active-low glyph.
    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } dec_vec_t;
    dec_vec_t dec_vecs[16];

    // Reference model: position within the frame plus the values captured at frame start.
    logic [31:0] m_data;
    logic [7:0]  m_en;
    logic [7:0]  m_dp;
    int          m_pos;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn;
    logic        e_ft;

    int low_cnt[8];
    int first_low[8];
    int tick_cnt;
    int dp_low;
    int dp_low_d7;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] r;
        r = 7'h7F;
        for (int i = 0; i < 16; i++)
            if (dec_vecs[i].nib == n) r = dec_vecs[i].seg;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_data = '0;
        m_en   = '0;
        m_dp   = '0;
    endtask

    // One clock: predict the registered outputs from the frame position before
    // the edge, then compare on the falling edge.
    task automatic step();
        int d;
        int off;
        @(posedge clk);
        d    = m_pos / DC;
        off  = m_pos % DC;
        e_ft = (m_pos == 0);
        if (off < BC) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_dpn = 1'b1;
        end else begin
            e_an = 8'hFF;
            if (m_en[d]) e_an[d] = 1'b0;
            e_seg = ref_seg(m_data[4*d +: 4]);
            e_dpn = ~m_dp[d];
        end
        if (m_pos == 0) begin
            m_data = data;
            m_en   = digit_en;
            m_dp   = dp;
        end
        m_pos = (m_pos + 1) % FRAME;
        @(negedge clk);
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dpn));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        check("one_anode", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < FRAME + 6 && !seen; k++) begin
            step();
            if (frame_tick) seen = 1'b1;
        end
        check("tick_seen", 32'(seen), 32'd1);
    endtask

    // 64 steps starting right after a frame_tick, collecting per-digit statistics.
    task automatic run_frame();
        for (int i = 0; i < 8; i++) begin
            low_cnt[i]   = 0;
            first_low[i] = 0;
        end
        tick_cnt  = 0;
        dp_low    = 0;
        dp_low_d7 = 0;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            for (int i = 0; i < 8; i++) begin
                if (an[i] == 1'b0) begin
                    low_cnt[i]++;
                    if (first_low[i] == 0) first_low[i] = k;
                end
            end
            if (frame_tick) tick_cnt++;
            if (!dp_n) begin
                dp_low++;
                if (!an[7]) dp_low_d7++;
            end
        end
    endtask

    // Reset asserted between edges; outputs must blank without a clock.
    task automatic do_reset_mid();
        #2;
        rst = 1'b1;
        #1;
        check("async_an", 32'(an), 32'hFF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp_n", 32'(dp_n), 32'd1);
        check("async_tick", 32'(frame_tick), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_an", 32'(an), 32'hFF);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [6:0] glyphs[16];
        glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 16; i++) begin
            dec_vecs[i].nib = 4'(i);
            dec_vecs[i].seg = glyphs[i];
        end

        rst      = 1'b1;
        data     = '0;
        digit_en = '0;
        dp       = '0;
        model_reset();

        // Reset held for five cycles.
        repeat (5) @(negedge clk);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp_n", 32'(dp_n), 32'd1);
        check("rst_tick", 32'(frame_tick), 32'd0);
        do_reset_mid();

        // First edge after release loads the snapshot and ticks next cycle.
        step();
        check("first_tick", 32'(frame_tick), 32'd1);

        // All digits enabled, counting digits.
        data     = 32'h76543210;
        digit_en = 8'hFF;
        wait_tick();
        run_frame();
        for (int i = 0; i < 8; i++)
            check($sformatf("all_en_low_%0d", i), 32'(low_cnt[i]), 32'd6);
        check("all_en_first_low_2", 32'(first_low[2]), 32'd18);
        check("tick_per_frame", 32'(tick_cnt), 32'd1);

        // Data changes while digit 3 is shown: current frame keeps old values.
        repeat (24) step();
        data = 32'hFFFFFFFF;
        for (int k = 25; k <= 63; k++) begin
            step();
            if (k == 26) check("old_d3_seg", 32'(seg), 32'h30);
            if (k == 58) check("old_d7_seg", 32'(seg), 32'h78);
        end
        step();
        check("new_frame_tick", 32'(frame_tick), 32'd1);
        step();
        check("new_d0_guard", 32'(seg), 32'h7F);
        step();
        check("new_d0_seg", 32'(seg), 32'h0E);

        // Only digits 0 and 2 enabled.
        digit_en = 8'b0000_0101;
        wait_tick();
        run_frame();
        check("en05_low_0", 32'(low_cnt[0]), 32'd6);
        check("en05_low_2", 32'(low_cnt[2]), 32'd6);
        check("en05_low_others", 32'(low_cnt[1] + low_cnt[3] + low_cnt[4] + low_cnt[5]
                                     + low_cnt[6] + low_cnt[7]), 32'd0);
        check("en05_first_low_2", 32'(first_low[2]), 32'd18);

        // Decimal point only on digit 7.
        digit_en = 8'hFF;
        dp       = 8'h80;
        wait_tick();
        run_frame();
        check("dp80_low", 32'(dp_low), 32'd6);
        check("dp80_low_on_d7", 32'(dp_low_d7), 32'd6);

        // Reset while digit 5 is lit, then restart from digit 0.
        dp = 8'h00;
        wait_tick();
        repeat (42) step();
        check("pre_rst_d5_lit", 32'(an), 32'hDF);
        do_reset_mid();
        step();
        check("post_rst_tick", 32'(frame_tick), 32'd1);
        step();
        step();
        check("post_rst_an0", 32'(an[0]), 32'd0);

        // Decode table, one glyph per frame on every digit.
        for (int v = 0; v < 16; v++) begin
            data = {8{dec_vecs[v].nib}};
            wait_tick();
            step();
            step();
            check($sformatf("decode_%h", dec_vecs[v].nib), 32'(seg), 32'(dec_vecs[v].seg));
        end

        // Random inputs changing at arbitrary points, occasional mid-frame reset.
        for (int r = 0; r < 25; r++) begin
            data     = $urandom;
            digit_en = 8'($urandom_range(0, 255));
            dp       = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 150)) step();
            if ($urandom_range(0, 7) == 0) do_reset_mid();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
